// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter + 4:1 mux into one registered output; accepted word appears one cycle later.
// in_ready is zero while the output register is full and not being drained; priority rotates only on accept.
module rr_mux_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  logic [1:0]       last_q;
  logic             can_load;
  logic             gnt_vld;
  logic [1:0]       gnt_idx;
  logic [1:0]       idx;
  logic [WIDTH-1:0] mux_dat;

  assign can_load = !out_valid || out_ready;

  // Search order last+1, last+2, last+3, last; the 2-bit add wraps naturally.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    idx     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + k[1:0];
      if (!gnt_vld && in_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    if (!can_load) begin
      gnt_vld = 1'b0;
    end
  end

  always_comb begin
    in_ready = 4'b0000;
    if (gnt_vld) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  // Only the granted requester's data reaches the register.
  always_comb begin
    case (gnt_idx)
      2'd0:    mux_dat = in_data0;
      2'd1:    mux_dat = in_data1;
      2'd2:    mux_dat = in_data2;
      default: mux_dat = in_data3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
      last_q    <= 2'd3;
    end else if (gnt_vld) begin
      out_valid <= 1'b1;
      out_data  <= mux_dat;
      out_src   <= gnt_idx;
      last_q    <= gnt_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with hand-computed expectations.
module tb_rr_mux_arbiter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [3:0]       in_valid;
  logic [WIDTH-1:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             out_ready;

  int n_tests;
  int n_fail;

  rr_mux_arbiter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data0 (in_data0),
    .in_data1 (in_data1),
    .in_data2 (in_data2),
    .in_data3 (in_data3),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_src  (out_src),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [3:0] exp_rdy1 [5];
  logic [3:0] exp_dat1 [5];
  logic [1:0] exp_src1 [5];

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    in_valid  = 4'b0000;
    in_data0  = 4'hA;
    in_data1  = 4'hB;
    in_data2  = 4'hC;
    in_data3  = 4'hD;
    out_ready = 1'b0;

    exp_rdy1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_dat1 = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    exp_src1 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset state
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_src",   32'(out_src),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);

    // All four requesting, consumer always ready: strict rotation at full rate
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("rr_in_ready%0d", i), 32'(in_ready), 32'(exp_rdy1[i]));
      step();
      chk($sformatf("rr_out_data%0d", i),  32'(out_data),  32'(exp_dat1[i]));
      chk($sformatf("rr_out_src%0d", i),   32'(out_src),   32'(exp_src1[i]));
      chk($sformatf("rr_out_valid%0d", i), 32'(out_valid), 32'd1);
    end

    // Single requester 2
    in_valid = 4'b0100;
    in_data2 = 4'h7;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("one_in_ready%0d", i), 32'(in_ready), 32'b0100);
      step();
      chk($sformatf("one_out_data%0d", i), 32'(out_data), 32'h7);
      chk($sformatf("one_out_src%0d", i),  32'(out_src),  32'd2);
    end

    // Backpressure: load 5 from requester 1, then stall three cycles
    do_reset();
    in_data0  = 4'h1;
    in_data1  = 4'h5;
    in_data2  = 4'h9;
    in_data3  = 4'h3;
    in_valid  = 4'b0010;
    out_ready = 1'b1;
    #1;
    chk("bp_load_ready", 32'(in_ready), 32'b0010);
    step();
    chk("bp_load_data", 32'(out_data), 32'h5);
    chk("bp_load_src",  32'(out_src),  32'd1);
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_stall_ready%0d", i), 32'(in_ready), 32'd0);
      step();
      chk($sformatf("bp_stall_data%0d", i),  32'(out_data),  32'h5);
      chk($sformatf("bp_stall_src%0d", i),   32'(out_src),   32'd1);
      chk($sformatf("bp_stall_valid%0d", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'b0100);
    step();
    chk("bp_release_data", 32'(out_data), 32'h9);
    chk("bp_release_src",  32'(out_src),  32'd2);

    // Drain to empty
    in_valid = 4'b0000;
    #1;
    chk("drain_ready", 32'(in_ready), 32'd0);
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_data",  32'(out_data),  32'h9);
    step();
    chk("drain_idle_valid", 32'(out_valid), 32'd0);
    chk("drain_idle_ready", 32'(in_ready),  32'd0);

    // Pointer hold across idle cycles
    do_reset();
    in_data0 = 4'h3;
    in_valid = 4'b0010;
    step();
    chk("ptr_first_src", 32'(out_src), 32'd1);
    in_valid = 4'b0000;
    repeat (5) step();
    chk("ptr_idle_valid", 32'(out_valid), 32'd0);
    in_valid = 4'b0011;
    #1;
    chk("ptr_wrap_ready", 32'(in_ready), 32'b0001);
    step();
    chk("ptr_wrap_src",  32'(out_src),  32'd0);
    chk("ptr_wrap_data", 32'(out_data), 32'h3);

    // Reset while stalled with a held word
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    step();
    chk("rs_held_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_out_data",  32'(out_data),  32'd0);
    chk("rs_out_src",   32'(out_src),   32'd0);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("rs_next_ready", 32'(in_ready), 32'b0001);
    step();
    chk("rs_next_src", 32'(out_src), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
